cdc_fifo_rptr_level: RTL and testbench

Read-side pointer, empty and fill-level generator for the async (dual-clock) FIFO, in the r_clk domain. Successor to the plain read-pointer/empty block, with the same Gray-pointer contract toward the write domain.
- Adds a registered occupancy count derived from the synchronised write pointer.
- Adds a programmable almost-empty flag.
- Adds an optional sticky underflow error.
- Drops into the FIFO top in place of the old read-side block. The write side and synchronisers are unchanged.

---
 rtl/cdc_fifo_rptr_level_pkg.sv | 21 ++
 rtl/cdc_fifo_gray2bin.sv | 13 +
 rtl/cdc_fifo_rptr_level.sv | 83 ++++++++
 tb/tb_cdc_fifo_rptr_level.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cdc_fifo_rptr_level_pkg.sv
// Shared Gray-code helpers for the async FIFO pointer blocks (read and write side).
// Optional feature macro used by the read side: CDC_FIFO_RPTR_UNDERFLOW_EN.
package cdc_fifo_rptr_level_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    // Callers zero-extend narrower pointers, so the upper bits stay zero in both directions.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/cdc_fifo_gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module cdc_fifo_gray2bin #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/cdc_fifo_rptr_level.sv
// Read-side pointer, empty, almost-empty and fill-level generator for the dual-clock FIFO (r_clk domain).
// Define CDC_FIFO_RPTR_UNDERFLOW_EN to enable the sticky underflow flag.
module cdc_fifo_rptr_level
    import cdc_fifo_rptr_level_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 4
) (
    input  logic                 r_clk,
    input  logic                 r_rst_n,
    input  logic                 r_inc,
    input  logic [ADDR_SIZE:0]   r_q2_wptr,
    input  logic [ADDR_SIZE:0]   r_aempty_thresh,
    input  logic                 r_clr_err,
    output logic [ADDR_SIZE:0]   r_ptr,
    output logic [ADDR_SIZE-1:0] r_addr,
    output logic                 r_empty,
    output logic                 r_aempty,
    output logic [ADDR_SIZE:0]   r_count,
    output logic                 r_underflow
);

    localparam int unsigned PW    = ADDR_SIZE + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_SIZE;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_bin_next;
    logic [PW-1:0] r_gray_next;
    logic [PW-1:0] w_bin_sync;
    logic [PW-1:0] cnt_next;
    logic          rd_ok;

    cdc_fifo_gray2bin #(
        .W (PW)
    ) u_wptr_dec (
        .gray (r_q2_wptr),
        .bin  (w_bin_sync)
    );

    // Next pointer and level; modular subtraction keeps the count right across the MSB wrap.
    always_comb begin
        rd_ok       = r_inc & ~r_empty;
        r_bin_next  = r_bin + PW'(rd_ok);
        r_gray_next = PW'(bin2gray(GRAY_MAX_W'(r_bin_next)));
        cnt_next    = w_bin_sync - r_bin_next;
    end

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_bin    <= '0;
            r_ptr    <= '0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
            r_count  <= '0;
        end else begin
            r_bin    <= r_bin_next;
            r_ptr    <= r_gray_next;
            r_empty  <= (r_gray_next == r_q2_wptr);
            r_aempty <= (cnt_next <= r_aempty_thresh);
            r_count  <= cnt_next;
        end
    end

    assign r_addr = r_bin[AW-1:0];

`ifdef CDC_FIFO_RPTR_UNDERFLOW_EN
    // Sticky error: a read attempt against an empty FIFO beats a same-cycle clear.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_underflow <= 1'b0;
        end else if (r_inc && r_empty) begin
            r_underflow <= 1'b1;
        end else if (r_clr_err) begin
            r_underflow <= 1'b0;
        end
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = r_clr_err;
    assign r_underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_fifo_rptr_level.sv
// Self-checking bench for cdc_fifo_rptr_level (ADDR_SIZE=4): occupancy model plus directed literal checks.
module tb_cdc_fifo_rptr_level;

    logic       r_clk = 1'b0;
    logic       r_rst_n = 1'b0;
    logic       r_inc = 1'b0;
    logic [4:0] r_q2_wptr;
    logic [4:0] r_aempty_thresh = 5'd1;
    logic       r_clr_err = 1'b0;
    logic [4:0] r_ptr;
    logic [3:0] r_addr;
    logic       r_empty;
    logic       r_aempty;
    logic [4:0] r_count;
    logic       r_underflow;

    logic [4:0] w_bin = 5'd5;

    int errors = 0;
    int checks = 0;

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    assign r_q2_wptr = to_gray(w_bin);

    cdc_fifo_rptr_level #(.ADDR_SIZE(4)) dut (
        .r_clk           (r_clk),
        .r_rst_n         (r_rst_n),
        .r_inc           (r_inc),
        .r_q2_wptr       (r_q2_wptr),
        .r_aempty_thresh (r_aempty_thresh),
        .r_clr_err       (r_clr_err),
        .r_ptr           (r_ptr),
        .r_addr          (r_addr),
        .r_empty         (r_empty),
        .r_aempty        (r_aempty),
        .r_count         (r_count),
        .r_underflow     (r_underflow)
    );

    always #5 r_clk = ~r_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: reads done so far (mod 32) and the flags derived from occupancy.
    logic [4:0] m_rbin = '0;
    logic [4:0] m_count = '0;
    logic       m_empty = 1'b1;
    logic       m_aempty = 1'b1;
    logic       m_under = 1'b0;

    task automatic model_reset();
        m_rbin   = '0;
        m_count  = '0;
        m_empty  = 1'b1;
        m_aempty = 1'b1;
        m_under  = 1'b0;
    endtask

    always @(negedge r_rst_n) model_reset();

    always @(posedge r_clk) begin
        if (!r_rst_n) begin
            model_reset();
        end else begin
`ifdef CDC_FIFO_RPTR_UNDERFLOW_EN
            if (r_inc && m_empty) m_under = 1'b1;
            else if (r_clr_err)   m_under = 1'b0;
`endif
            if (r_inc && !m_empty) m_rbin = m_rbin + 5'd1;
            m_count  = w_bin - m_rbin;
            m_empty  = (m_count == 5'd0);
            m_aempty = (m_count <= r_aempty_thresh);
        end
        #1;
        chk("model_ptr",    int'(r_ptr),       int'(to_gray(m_rbin)));
        chk("model_addr",   int'(r_addr),      int'(m_rbin[3:0]));
        chk("model_count",  int'(r_count),     int'(m_count));
        chk("model_empty",  int'(r_empty),     int'(m_empty));
        chk("model_aempty", int'(r_aempty),    int'(m_aempty));
        chk("model_under",  int'(r_underflow), int'(m_under));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge r_clk);
        #2;
    endtask

    localparam int UF = `ifdef CDC_FIFO_RPTR_UNDERFLOW_EN 1 `else 0 `endif;

    initial begin
        // Reset held with a non-zero write pointer.
        tick(2);
        chk("rst_empty",  int'(r_empty), 1);
        chk("rst_aempty", int'(r_aempty), 1);
        chk("rst_count",  int'(r_count), 0);
        chk("rst_ptr",    int'(r_ptr), 0);
        chk("rst_addr",   int'(r_addr), 0);
        r_rst_n = 1'b1;
        tick(1);
        chk("rel_count", int'(r_count), 5);
        chk("rel_empty", int'(r_empty), 0);

        // Drain three words.
        w_bin = 5'd3;
        tick(1);
        chk("drain_c3", int'(r_count), 3);
        chk("drain_a0", int'(r_addr), 0);
        r_inc = 1'b1;
        tick(1);
        chk("drain_c2", int'(r_count), 2);
        chk("drain_a1", int'(r_addr), 1);
        chk("drain_ae_lo", int'(r_aempty), 0);
        tick(1);
        chk("drain_c1", int'(r_count), 1);
        chk("drain_ae_hi", int'(r_aempty), 1);
        chk("drain_e_lo", int'(r_empty), 0);
        tick(1);
        chk("drain_c0", int'(r_count), 0);
        chk("drain_e_hi", int'(r_empty), 1);
        chk("drain_a3", int'(r_addr), 3);
        r_inc = 1'b0;

        // Wrap: advance reads to r_bin=30, then write pointer wraps to 2.
        w_bin = 5'd30;
        tick(1);
        chk("wrap_pre", int'(r_count), 27);
        r_inc = 1'b1;
        tick(27);
        r_inc = 1'b0;
        chk("wrap_at30_e", int'(r_empty), 1);
        chk("wrap_at30_p", int'(r_ptr), 17);
        w_bin = 5'd2;
        tick(1);
        chk("wrap_cnt4", int'(r_count), 4);
        r_inc = 1'b1;
        tick(4);
        r_inc = 1'b0;
        chk("wrap_ptr", int'(r_ptr), 3);
        chk("wrap_addr", int'(r_addr), 2);
        chk("wrap_empty", int'(r_empty), 1);

        // Full level after a reset pulse.
        r_rst_n = 1'b0;
        tick(1);
        r_rst_n = 1'b1;
        w_bin = 5'd16;
        r_aempty_thresh = 5'd8;
        tick(1);
        chk("full_q2", int'(r_q2_wptr), 24);
        chk("full_count", int'(r_count), 16);
        chk("full_aempty", int'(r_aempty), 0);
        r_aempty_thresh = 5'd16;
        tick(1);
        chk("thr16_aempty", int'(r_aempty), 1);
        r_aempty_thresh = 5'd0;
        tick(1);
        chk("thr0_aempty", int'(r_aempty), 0);

        // Underflow: read attempt while empty.
        w_bin = 5'd0;
        tick(1);
        chk("uf_empty", int'(r_empty), 1);
        chk("thr0_ae_eq_e", int'(r_aempty), 1);
        r_inc = 1'b1;
        tick(1);
        r_inc = 1'b0;
        chk("uf_ptr", int'(r_ptr), 0);
        chk("uf_set", int'(r_underflow), UF);
        tick(2);
        chk("uf_hold", int'(r_underflow), UF);
        r_clr_err = 1'b1;
        tick(1);
        r_clr_err = 1'b0;
        chk("uf_clr", int'(r_underflow), 0);
        r_inc = 1'b1;
        r_clr_err = 1'b1;
        tick(1);
        r_inc = 1'b0;
        r_clr_err = 1'b0;
        chk("uf_set_wins", int'(r_underflow), UF);

        // Async reset in the middle of a drain.
        r_aempty_thresh = 5'd1;
        w_bin = 5'd7;
        tick(1);
        chk("mid_count7", int'(r_count), 7);
        r_inc = 1'b1;
        #1;
        r_rst_n = 1'b0;
        #1;
        chk("arst_count",  int'(r_count), 0);
        chk("arst_empty",  int'(r_empty), 1);
        chk("arst_aempty", int'(r_aempty), 1);
        chk("arst_ptr",    int'(r_ptr), 0);
        chk("arst_addr",   int'(r_addr), 0);
        chk("arst_under",  int'(r_underflow), 0);
        r_inc = 1'b0;
        tick(1);
        r_rst_n = 1'b1;
        tick(1);
        chk("post_count", int'(r_count), 7);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
